// File: rtl/risc_pkg.sv
// Shared encodings for the RISC controller: opcodes, ALU codes, FSM states,
// instruction field positions and the decoded-instruction record.
package risc_pkg;
  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  localparam int OPC_LSB = 13;
  localparam int OP_LSB  = 11;
  localparam int RN_LSB  = 8;
  localparam int RD_LSB  = 5;
  localparam int SH_LSB  = 3;
  localparam int RM_LSB  = 0;
  localparam int IMM_W   = 8;

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_WR_IMM
  } state_t;

  typedef enum logic [2:0] {
    C_ILLEGAL, C_MOV_IMM, C_MOV_REG, C_ADD_AND, C_CMP, C_MVN
  } iclass_t;

  typedef struct packed {
    logic [2:0] rn;
    logic [2:0] rd;
    logic [2:0] rm;
    logic [1:0] sh;
    logic [1:0] op;
    iclass_t    cls;
  } dec_t;
endpackage

// File: rtl/risc_instr_dec.sv
// Combinational instruction decoder: field extraction, imm8 sign-extension,
// legality check and instruction class.
module risc_instr_dec
  import risc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [15:0]      ir,
  output dec_t             dec,
  output logic [WIDTH-1:0] sximm8
);
  logic [2:0] opc;

  assign opc    = ir[OPC_LSB +: 3];
  assign sximm8 = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  always_comb begin
    dec.rn  = ir[RN_LSB +: 3];
    dec.rd  = ir[RD_LSB +: 3];
    dec.rm  = ir[RM_LSB +: 3];
    dec.sh  = ir[SH_LSB +: 2];
    dec.op  = ir[OP_LSB +: 2];
    dec.cls = C_ILLEGAL;
    case (opc)
      OPC_MOV: begin
        if (dec.op == OP_MOV_IMM)      dec.cls = C_MOV_IMM;
        else if (dec.op == OP_MOV_REG) dec.cls = C_MOV_REG;
      end
      OPC_ALU: begin
        case (dec.op)
          OP_ADD, OP_AND: dec.cls = C_ADD_AND;
          OP_CMP:         dec.cls = C_CMP;
          OP_MVN:         dec.cls = C_MVN;
          default:        dec.cls = C_ILLEGAL;
        endcase
      end
      default: dec.cls = C_ILLEGAL;
    endcase
  end
endmodule

// File: rtl/risc_controller.sv
// Multi-cycle Moore controller for the simple RISC datapath.
// Define RISC_CTRL_ILLEGAL_EN to get a sticky illegal-instruction err flag.
module risc_controller
  import risc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s,
  input  logic [15:0]      instr,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             vsel,
  output logic             loada,
  output logic             loadb,
  output logic             asel,
  output logic             bsel,
  output logic             loadc,
  output logic             loads,
  output logic             write,
  output logic [1:0]       shift,
  output logic [1:0]       ALUop,
  output logic [WIDTH-1:0] datapath_in,
  output logic             err
);
  state_t      state, nxt;
  logic [15:0] ir;
  dec_t        dec;

  risc_instr_dec #(.WIDTH(WIDTH)) u_dec (
    .ir     (ir),
    .dec    (dec),
    .sximm8 (datapath_in)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_WAIT:   if (s) nxt = S_DECODE;
      S_DECODE: begin
        case (dec.cls)
          C_MOV_IMM:         nxt = S_WR_IMM;
          C_MOV_REG, C_MVN:  nxt = S_GET_B;
          C_ADD_AND, C_CMP:  nxt = S_GET_A;
          default:           nxt = S_WAIT;
        endcase
      end
      S_GET_A:  nxt = S_GET_B;
      S_GET_B:  nxt = S_ALU;
      S_ALU:    nxt = (dec.cls == C_CMP) ? S_WAIT : S_WR_REG;
      default:  nxt = S_WAIT;
    endcase
  end

  // Outputs are registered as a decode of the state being entered, so they
  // line up with the state register and never see s/instr combinationally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_WAIT;
      ir       <= '0;
      w        <= 1'b1;
      readnum  <= '0;
      writenum <= '0;
      vsel     <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      write    <= 1'b0;
      shift    <= '0;
      ALUop    <= '0;
`ifdef RISC_CTRL_ILLEGAL_EN
      err      <= 1'b0;
`endif
    end else begin
      state    <= nxt;
      if (state == S_WAIT && s) ir <= instr;
      w        <= (nxt == S_WAIT);
      readnum  <= '0;
      writenum <= '0;
      vsel     <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      write    <= 1'b0;
      shift    <= '0;
      ALUop    <= '0;
      case (nxt)
        S_GET_A: begin
          loada   <= 1'b1;
          readnum <= dec.rn;
        end
        S_GET_B: begin
          loadb   <= 1'b1;
          readnum <= dec.rm;
        end
        S_ALU: begin
          shift <= dec.sh;
          ALUop <= (dec.cls == C_MOV_REG) ? ALU_ADD : dec.op;
          asel  <= (dec.cls == C_MOV_REG) || (dec.cls == C_MVN);
          loads <= (dec.cls == C_CMP);
          loadc <= (dec.cls != C_CMP);
        end
        S_WR_REG: begin
          write    <= 1'b1;
          writenum <= dec.rd;
        end
        S_WR_IMM: begin
          write    <= 1'b1;
          vsel     <= 1'b1;
          writenum <= dec.rn;
        end
        default: ;
      endcase
`ifdef RISC_CTRL_ILLEGAL_EN
      if (state == S_DECODE && dec.cls == C_ILLEGAL) err <= 1'b1;
`endif
    end
  end

`ifndef RISC_CTRL_ILLEGAL_EN
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_risc_controller.sv
// Directed, table-driven bench for risc_controller plus hand-written reset,
// handshake and sticky-err sequences.
module tb_risc_controller;
  localparam int WIDTH = 16;
`ifdef RISC_CTRL_ILLEGAL_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk, reset_n, s;
  logic [15:0] instr;
  logic w, vsel, loada, loadb, asel, bsel, loadc, loads, write, err;
  logic [2:0] readnum, writenum;
  logic [1:0] shift, ALUop;
  logic [WIDTH-1:0] datapath_in;
  logic [18:0] outv;

  int n_chk = 0;
  int n_fail = 0;

  risc_controller #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .s(s), .instr(instr), .w(w),
    .readnum(readnum), .writenum(writenum), .vsel(vsel), .loada(loada),
    .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .write(write), .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in),
    .err(err)
  );

  assign outv = {w, vsel, loada, loadb, asel, bsel, loadc, loads, write,
                 readnum, writenum, shift, ALUop};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [15:0] instr;
    logic [18:0] exp;
    logic [15:0] dp;
  } vec_t;
  vec_t tv[$];

  localparam logic [18:0] E_IDLE = {1'b1, 18'd0};
  localparam logic [18:0] E_DEC  = 19'd0;

  function automatic logic [18:0] e_ga(input logic [2:0] r);
    return {1'b0, 1'b0, 1'b1, 6'b0, r, 3'd0, 4'd0};
  endfunction
  function automatic logic [18:0] e_gb(input logic [2:0] r);
    return {3'b0, 1'b1, 5'b0, r, 3'd0, 4'd0};
  endfunction
  function automatic logic [18:0] e_alu(input logic as, input logic lc, input logic ls,
                                        input logic [1:0] sh, input logic [1:0] aop);
    return {4'b0, as, 1'b0, lc, ls, 1'b0, 6'd0, sh, aop};
  endfunction
  function automatic logic [18:0] e_wrr(input logic [2:0] rd);
    return {8'b0, 1'b1, 3'd0, rd, 4'd0};
  endfunction
  function automatic logic [18:0] e_wri(input logic [2:0] rn);
    return {1'b0, 1'b1, 6'b0, 1'b1, 3'd0, rn, 4'd0};
  endfunction

  task automatic add(input logic sv, input logic [15:0] iv, input logic [18:0] ev,
                     input logic [15:0] dv);
    vec_t v;
    v.s = sv; v.instr = iv; v.exp = ev; v.dp = dv;
    tv.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic sv, input logic [15:0] iv);
    @(negedge clk);
    s = sv;
    instr = iv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; s = 1'b0; instr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", 0, {13'd0, outv}, {13'd0, E_IDLE});
    chk("reset_dp", 0, {16'd0, datapath_in}, 32'h0);
    chk("reset_err", 0, {31'd0, err}, 32'h0);
    @(negedge clk) reset_n = 1'b1;

    // MOV R3,#-2
    add(1, 16'hD3FE, E_DEC, 16'hFFFE);
    add(0, 16'h0000, e_wri(3), 16'hFFFE);
    add(0, 16'h0000, E_IDLE, 16'hFFFE);
    // ADD R2,R1,R0 LSL-ish sh=01: accept + 5 states, back in WAIT after WR_REG
    add(1, 16'hA148, E_DEC, 16'h0048);
    add(0, 16'hA148, e_ga(1), 16'h0048);
    add(0, 16'hA148, e_gb(0), 16'h0048);
    add(0, 16'hA148, e_alu(0, 1, 0, 2'b01, 2'b00), 16'h0048);
    add(0, 16'hA148, e_wrr(2), 16'h0048);
    add(0, 16'hA148, E_IDLE, 16'h0048);
    // CMP R1,R0: no write
    add(1, 16'hA900, E_DEC, 16'h0000);
    add(0, 16'h0000, e_ga(1), 16'h0000);
    add(0, 16'h0000, e_gb(0), 16'h0000);
    add(0, 16'h0000, e_alu(0, 0, 1, 2'b00, 2'b01), 16'h0000);
    add(0, 16'h0000, E_IDLE, 16'h0000);
    // AND R5,R4,R6 sh=10
    add(1, 16'hB4B6, E_DEC, 16'hFFB6);
    add(0, 16'h0000, e_ga(4), 16'hFFB6);
    add(0, 16'h0000, e_gb(6), 16'hFFB6);
    add(0, 16'h0000, e_alu(0, 1, 0, 2'b10, 2'b10), 16'hFFB6);
    add(0, 16'h0000, e_wrr(5), 16'hFFB6);
    add(0, 16'h0000, E_IDLE, 16'hFFB6);
    // MVN R7,R2 sh=11
    add(1, 16'hB8FA, E_DEC, 16'hFFFA);
    add(0, 16'h0000, e_gb(2), 16'hFFFA);
    add(0, 16'h0000, e_alu(1, 1, 0, 2'b11, 2'b11), 16'hFFFA);
    add(0, 16'h0000, e_wrr(7), 16'hFFFA);
    add(0, 16'h0000, E_IDLE, 16'hFFFA);
    // MOV R1,R5
    add(1, 16'hC025, E_DEC, 16'h0025);
    add(0, 16'h0000, e_gb(5), 16'h0025);
    add(0, 16'h0000, e_alu(1, 1, 0, 2'b00, 2'b00), 16'h0025);
    add(0, 16'h0000, e_wrr(1), 16'h0025);
    add(0, 16'h0000, E_IDLE, 16'h0025);
    // MOV R7,#127
    add(1, 16'hD77F, E_DEC, 16'h007F);
    add(0, 16'h0000, e_wri(7), 16'h007F);
    add(0, 16'h0000, E_IDLE, 16'h007F);
    // ADD again with s pulsed during GET_B and ALU carrying a different instr
    add(1, 16'hA148, E_DEC, 16'h0048);
    add(0, 16'h0000, e_ga(1), 16'h0048);
    add(0, 16'h0000, e_gb(0), 16'h0048);
    add(1, 16'hD3FE, e_alu(0, 1, 0, 2'b01, 2'b00), 16'h0048);
    add(1, 16'hD3FE, e_wrr(2), 16'h0048);
    add(0, 16'h0000, E_IDLE, 16'h0048);
    // Illegal: opcode 111, then MOV with op 01
    add(1, 16'hE000, E_DEC, 16'h0000);
    add(0, 16'h0000, E_IDLE, 16'h0000);
    add(1, 16'hC800, E_DEC, 16'h0000);
    add(0, 16'h0000, E_IDLE, 16'h0000);

    chk("err_before_illegal", 0, {31'd0, err}, 32'h0);
    foreach (tv[i]) begin
      step(tv[i].s, tv[i].instr);
      chk("vec_out", i, {13'd0, outv}, {13'd0, tv[i].exp});
      chk("vec_dp", i, {16'd0, datapath_in}, {16'd0, tv[i].dp});
    end
    chk("err_after_illegal", 0, {31'd0, err}, {31'd0, ERR_EXP});

    // Reset during ALU of an ADD aborts with no write
    step(1, 16'hA148);
    step(0, 16'h0000);
    step(0, 16'h0000);
    step(0, 16'h0000);
    chk("abort_in_alu", 0, {13'd0, outv}, {13'd0, e_alu(0, 1, 0, 2'b01, 2'b00)});
    #1 reset_n = 1'b0;
    #1;
    chk("abort_async_out", 0, {13'd0, outv}, {13'd0, E_IDLE});
    chk("abort_dp", 0, {16'd0, datapath_in}, 32'h0);
    chk("abort_err", 0, {31'd0, err}, 32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      chk("abort_no_write", k, {13'd0, outv}, {13'd0, E_IDLE});
    end

    // First accept on the first rising edge after reset release
    @(negedge clk);
    reset_n = 1'b1; s = 1'b1; instr = 16'hD3FE;
    @(posedge clk);
    #1;
    chk("first_accept", 0, {13'd0, outv}, {13'd0, E_DEC});
    chk("first_accept_dp", 0, {16'd0, datapath_in}, 32'h0000FFFE);
    step(0, 16'h0000);
    chk("first_wr_imm", 0, {13'd0, outv}, {13'd0, e_wri(3)});
    step(0, 16'h0000);
    chk("first_done", 0, {13'd0, outv}, {13'd0, E_IDLE});

    // err sets on illegal, survives a later legal instruction
    step(1, 16'hE000);
    step(0, 16'h0000);
    chk("illegal_nop", 0, {13'd0, outv}, {13'd0, E_IDLE});
    chk("err_set", 0, {31'd0, err}, {31'd0, ERR_EXP});
    step(1, 16'hD77F);
    step(0, 16'h0000);
    step(0, 16'h0000);
    chk("err_sticky_out", 0, {13'd0, outv}, {13'd0, E_IDLE});
    chk("err_sticky", 0, {31'd0, err}, {31'd0, ERR_EXP});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/risc_controller.md
RISC_CONTROLLER -- requirements
Module: risc_controller

Interface
REQ-001 Parameter: WIDTH, 16, datapath word width; all word ports are WIDTH bits.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 Port: clk, in, 1, rising-edge clock.
REQ-004 Port: reset_n, in, 1, asynchronous active-low reset.
REQ-005 Port: s, in, 1, start request; sampled only in WAIT.
REQ-006 Port: instr, in, 16, instruction; captured on accepted start.
REQ-007 Port: w, out, 1, idle/ready; high only in WAIT.
REQ-008 Ports (outputs to datapath):
- readnum, writenum: 3 bits each.
- vsel, loada, loadb, asel, bsel, loadc, loads, write: 1 bit each.
- shift, ALUop: 2 bits each.
- datapath_in: WIDTH bits.
REQ-009 Port: err, out, 1, illegal-instruction flag (see Configuration).

Function
REQ-010 Instruction fields: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
REQ-011 Legal instructions:
- opcode 110, op 10: MOV Rn,#imm8.
- opcode 110, op 00: MOV Rd,Rm,sh.
- opcode 101, op 00/01/10/11: ADD / CMP / AND / MVN.
- Any other opcode/op combination is illegal.
REQ-012 States: WAIT, DECODE, GET_A, GET_B, ALU, WR_REG, WR_IMM; one state per cycle; no other waits.
REQ-013 Start handshake: in WAIT, s=1 latches instr into an internal register and moves to DECODE next edge; s is ignored in every other state; instr changes after acceptance have no effect.
REQ-014 Sequences (DECODE through return to WAIT):
- MOV imm: DECODE -> WR_IMM -> WAIT.
- MOV reg and MVN: DECODE -> GET_B -> ALU -> WR_REG -> WAIT.
- ADD and AND: DECODE -> GET_A -> GET_B -> ALU -> WR_REG -> WAIT.
- CMP: DECODE -> GET_A -> GET_B -> ALU -> WAIT.
REQ-015 Default strobes: every 1-bit strobe SHALL be 0 in every state unless a requirement below sets it.
REQ-016 GET_A: loada=1, readnum=Rn.
REQ-017 GET_B: loadb=1, readnum=Rm.
REQ-018 ALU state:
- shift=sh, bsel=0, ALUop=op for opcode 101; ALUop=00 with asel=1 (zero A operand) for MOV reg.
- MVN also drives asel=1.
- CMP drives loads=1 and loadc=0; all other instructions drive loadc=1 and loads=0.
REQ-019 WR_REG: write=1, vsel=0 (select C), writenum=Rd.
REQ-020 WR_IMM: write=1, vsel=1 (select datapath_in), writenum=Rn.
REQ-021 datapath_in SHALL equal imm8 sign-extended to WIDTH bits from the latched instruction, in all states.
REQ-022 shift SHALL be 00 outside the ALU state.
REQ-023 Illegal instruction: DECODE -> WAIT with no strobes asserted.
REQ-024 All outputs are registered-state decodes (Moore); no output depends combinationally on s or instr.

Reset
REQ-025 reset_n=0 forces, asynchronously:
- state=WAIT, w=1;
- all strobes=0; readnum, writenum, shift, ALUop=0;
- latched instruction=0; err=0.
REQ-026 Reset asserted mid-sequence aborts the sequence; no write strobe is issued afterwards.
REQ-027 The first accept is possible on the first rising edge after reset_n deasserts.

Configuration
REQ-028 Macro RISC_CTRL_ILLEGAL_EN defined: err is set in DECODE when the instruction is illegal, is sticky, and is cleared only by reset.
REQ-029 Macro RISC_CTRL_ILLEGAL_EN undefined: err is tied to 0; illegal instructions behave as NOPs per REQ-023.

Structure
REQ-030 Package risc_pkg SHALL hold:
- opcode/op constants;
- ALUop codes: 00 add, 01 sub, 10 and, 11 not B;
- state enumeration;
- instruction field position constants.
REQ-031 One sub-module SHALL exist: risc_instr_dec, combinational field extraction, sign-extension, legality check and instruction-class output.

Verification
REQ-032 MOV R3,#-2 (instr=16'hD3FE), s=1 in WAIT -> WR_IMM on cycle 2 with write=1, vsel=1, writenum=3, datapath_in=16'hFFFE; w=1 on cycle 3.
REQ-033 ADD R2,R1,R0 with sh=01 (instr=16'hA148) -> GET_A readnum=1, GET_B readnum=0, ALU shift=01 ALUop=00 loadc=1, WR_REG writenum=2; 5 cycles from accept to w=1.
REQ-034 CMP R1,R0 (instr=16'hA900) -> ALU cycle loads=1, loadc=0; no write=1 in any cycle.
REQ-035 Pulse s during GET_B with a different instr -> ignored; original sequence completes unchanged.
REQ-036 Assert reset_n=0 during ALU of an ADD -> immediate WAIT, all strobes 0, no write.
REQ-037 instr=16'hE000 (illegal) -> DECODE -> WAIT, no strobes; err=1 with RISC_CTRL_ILLEGAL_EN, err=0 without it.
